// File: rtl/ps2_key_ctrl_if.sv
// FIFO-side bus of the PS/2 key controller: head byte, non-empty flag,
// overflow flag and the active-low pop strobe returned to the FIFO.
interface ps2_key_ctrl_if;
    logic [7:0] ps2_data;
    logic       ps2_ready;
    logic       ps2_overflow;
    logic       ps2_rdn;

    modport master (
        input  ps2_data,
        input  ps2_ready,
        input  ps2_overflow,
        output ps2_rdn
    );

    modport slave (
        output ps2_data,
        output ps2_ready,
        output ps2_overflow,
        input  ps2_rdn
    );
endinterface

// File: rtl/ps2_key_ctrl.sv
// PS/2 key controller: drains a keyboard FIFO, decodes E0/F0 prefixed scan codes
// into key events and a held-key bitmap. Define PS2_KEY_TIMEOUT_EN for prefix expiry.
module ps2_key_ctrl #(
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input  logic           clk,
    input  logic           clrn,
    ps2_key_ctrl_if.master fifo,
    output logic           key_valid,
    output logic [7:0]     key_code,
    output logic           key_break,
    output logic           key_ext,
    output logic [7:0]     key_state,
    output logic [7:0]     last_make,
    output logic           ovf_err,
    input  logic           clr_ovf
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
    localparam logic [7:0] BYTE_EXT = 8'hE0;
    localparam logic [7:0] BYTE_BRK = 8'hF0;

    // Held-key bit for a scan code; codes outside the map give an empty mask.
    function automatic logic [7:0] key_mask(input logic [7:0] code, input logic ext);
        logic [7:0] m;
        m = 8'h00;
        if (ext) begin
            case (code)
                8'h75:   m = 8'h10;
                8'h6B:   m = 8'h20;
                8'h72:   m = 8'h40;
                8'h74:   m = 8'h80;
                default: m = 8'h00;
            endcase
        end else begin
            case (code)
                8'h1D:   m = 8'h08;
                8'h1C:   m = 8'h04;
                8'h1B:   m = 8'h02;
                8'h23:   m = 8'h01;
                default: m = 8'h00;
            endcase
        end
        return m;
    endfunction

    state_e     state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic       rdn_q, rdn_d;
    logic       ext_pend_q, ext_pend_d;
    logic       brk_pend_q, brk_pend_d;
    logic       key_valid_q, key_valid_d;
    logic [7:0] key_code_q, key_code_d;
    logic       key_break_q, key_break_d;
    logic       key_ext_q, key_ext_d;
    logic [7:0] key_state_q, key_state_d;
    logic [7:0] last_make_q, last_make_d;
    logic       ovf_err_q, ovf_err_d;
    logic       ovf_prev_q, ovf_prev_d;
    logic       capture_s;
    logic       ovf_rise_s;
    logic [7:0] mask_s;

`ifdef PS2_KEY_TIMEOUT_EN
    localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYCLES - 1);
    logic [19:0] to_cnt_q, to_cnt_d;
`endif

    // State register for the pop sequencer, decoder and status flags.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= ST_IDLE;
            byte_q      <= 8'h00;
            gap_cnt_q   <= 4'd0;
            rdn_q       <= 1'b1;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            key_valid_q <= 1'b0;
            key_code_q  <= 8'h00;
            key_break_q <= 1'b0;
            key_ext_q   <= 1'b0;
            key_state_q <= 8'h00;
            last_make_q <= 8'h00;
            ovf_err_q   <= 1'b0;
            ovf_prev_q  <= 1'b0;
`ifdef PS2_KEY_TIMEOUT_EN
            to_cnt_q    <= 20'd0;
`endif
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            gap_cnt_q   <= gap_cnt_d;
            rdn_q       <= rdn_d;
            ext_pend_q  <= ext_pend_d;
            brk_pend_q  <= brk_pend_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_break_q <= key_break_d;
            key_ext_q   <= key_ext_d;
            key_state_q <= key_state_d;
            last_make_q <= last_make_d;
            ovf_err_q   <= ovf_err_d;
            ovf_prev_q  <= ovf_prev_d;
`ifdef PS2_KEY_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    // Next-state: FIFO pop sequencing, byte parsing, timeout and overflow handling.
    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        gap_cnt_d   = gap_cnt_q;
        rdn_d       = 1'b1;
        ext_pend_d  = ext_pend_q;
        brk_pend_d  = brk_pend_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_break_d = key_break_q;
        key_ext_d   = key_ext_q;
        key_state_d = key_state_q;
        last_make_d = last_make_q;
        ovf_err_d   = ovf_err_q;
        ovf_prev_d  = fifo.ps2_overflow;
        capture_s   = 1'b0;
        ovf_rise_s  = fifo.ps2_overflow & ~ovf_prev_q;
        mask_s      = key_mask(byte_q, ext_pend_q);

`ifdef PS2_KEY_TIMEOUT_EN
        // Evaluated before the parser so a prefix arriving in POP still wins.
        to_cnt_d = to_cnt_q;
        if (state_q == ST_IDLE && fifo.ps2_ready) begin
            to_cnt_d = 20'd0;
        end else if (ext_pend_q || brk_pend_q) begin
            if (to_cnt_q == TO_LAST) begin
                to_cnt_d   = 20'd0;
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
            end else begin
                to_cnt_d = to_cnt_q + 20'd1;
            end
        end else begin
            to_cnt_d = 20'd0;
        end
`endif

        case (state_q)
            ST_IDLE: begin
                if (fifo.ps2_ready) begin
                    capture_s = 1'b1;
                    byte_d    = fifo.ps2_data;
                    rdn_d     = 1'b0;
                    state_d   = ST_POP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_POP: begin
                state_d   = ST_GAP;
                gap_cnt_d = 4'd0;
                if (byte_q == BYTE_EXT) begin
                    ext_pend_d = 1'b1;
                end else if (byte_q == BYTE_BRK) begin
                    brk_pend_d = 1'b1;
                end else begin
                    key_valid_d = 1'b1;
                    key_code_d  = byte_q;
                    key_break_d = brk_pend_q;
                    key_ext_d   = ext_pend_q;
                    ext_pend_d  = 1'b0;
                    brk_pend_d  = 1'b0;
                    if (brk_pend_q) begin
                        key_state_d = key_state_q & ~mask_s;
                    end else begin
                        key_state_d = key_state_q | mask_s;
                        last_make_d = byte_q;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = 4'd0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                gap_cnt_d = 4'd0;
            end
        endcase

        // Overflow invalidates everything decoded so far; the sequencer keeps draining.
        if (ovf_rise_s) begin
            ovf_err_d   = 1'b1;
            key_state_d = 8'h00;
            ext_pend_d  = 1'b0;
            brk_pend_d  = 1'b0;
        end else if (clr_ovf) begin
            ovf_err_d = 1'b0;
        end else begin
            ovf_err_d = ovf_err_q;
        end
    end

    assign fifo.ps2_rdn = rdn_q;
    assign key_valid    = key_valid_q;
    assign key_code     = key_code_q;
    assign key_break    = key_break_q;
    assign key_ext      = key_ext_q;
    assign key_state    = key_state_q;
    assign last_make    = last_make_q;
    assign ovf_err      = ovf_err_q;
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Scoreboard bench for ps2_key_ctrl: a byte-level reference model predicts each key
// event when bytes are queued; an independent monitor checks events as they appear.
module tb_ps2_key_ctrl;
    localparam int GAP = 2;
    localparam int TMO = 100;
    localparam logic [7:0] MAP_CODE [0:7] = '{8'h23, 8'h1B, 8'h1C, 8'h1D,
                                              8'h75, 8'h6B, 8'h72, 8'h74};

    logic       clk = 1'b0;
    logic       clrn;
    logic       clr_ovf;
    logic       key_valid, key_break, key_ext, ovf_err;
    logic [7:0] key_code, key_state, last_make;

    int errors = 0;
    int checks = 0;

    // FIFO contents: written only by the stimulus, read pointer owned by the FIFO model.
    logic [7:0]  tx_mem [0:1023];
    int          tx_wr = 0;
    int          rd_idx = 0;
    int          rdn_pulses = 0;

    // Expected events {code, break, ext, key_state, last_make}.
    logic [25:0] exp_mem [0:1023];
    int          exp_wr = 0;
    int          exp_rd = 0;
    logic [25:0] got;

    logic       m_ext, m_brk;
    logic [7:0] m_held, m_last;
    int         p0, n;

    ps2_key_ctrl_if fif ();

    ps2_key_ctrl #(
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .clrn     (clrn),
        .fifo     (fif),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_break(key_break),
        .key_ext  (key_ext),
        .key_state(key_state),
        .last_make(last_make),
        .ovf_err  (ovf_err),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    always_comb begin
        fif.ps2_ready = (rd_idx != tx_wr);
        fif.ps2_data  = tx_mem[rd_idx[9:0]];
    end

    // FIFO model: a low strobe seen mid-cycle removes the head byte.
    always @(negedge clk) begin
        if (fif.ps2_rdn == 1'b0) begin
            rdn_pulses <= rdn_pulses + 1;
            if (rd_idx != tx_wr) rd_idx <= rd_idx + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference model: held keys are a bit per (code, extended) pair in the map table.
    task automatic model_byte(input logic [7:0] b);
        int idx;
        if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            idx = -1;
            for (int i = 0; i < 8; i++)
                if (MAP_CODE[i] == b && (i >= 4) == m_ext) idx = i;
            if (idx >= 0) m_held[idx] = ~m_brk;
            if (!m_brk) m_last = b;
            exp_mem[exp_wr[9:0]] = {b, m_brk, m_ext, m_held, m_last};
            exp_wr++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic model_clear(input logic full);
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_held = 8'h00;
        if (full) m_last = 8'h00;
    endtask

    task automatic send(input logic [7:0] b);
        tx_mem[tx_wr[9:0]] = b;
        tx_wr = tx_wr + 1;
        model_byte(b);
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((rd_idx != tx_wr || exp_rd != exp_wr) && w < 2000) begin
            tick(1);
            w++;
        end
        check("drain_timeout", 32'(w < 2000), 32'd1);
        tick(GAP + 4);
    endtask

    task automatic ovf_pulse();
        fif.ps2_overflow = 1'b1;
        tick(1);
        fif.ps2_overflow = 1'b0;
        model_clear(1'b0);
        check("ovf_set", ovf_err, 1'b1);
        check("ovf_clears_state", key_state, 8'h00);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        check("ovf_clr", ovf_err, 1'b0);
    endtask

    function automatic logic [7:0] rand_byte();
        int unsigned r;
        r = $urandom_range(0, 10);
        if (r < 8) return MAP_CODE[r];
        else if (r == 8) return 8'hE0;
        else if (r == 9) return 8'hF0;
        else return 8'($urandom_range(0, 255));
    endfunction

    // Monitor: every strobe must match the oldest outstanding prediction.
    initial begin
        forever begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                checks++;
                got = {key_code, key_break, key_ext, key_state, last_make};
                if (exp_rd == exp_wr) begin
                    errors++;
                    $display("FAIL event_unexpected: got %h, expected no event", got);
                end else begin
                    if (got !== exp_mem[exp_rd[9:0]]) begin
                        errors++;
                        $display("FAIL event_%0d: got {code,brk,ext,state,last}=%h, expected %h",
                                 exp_rd, got, exp_mem[exp_rd[9:0]]);
                    end
                    exp_rd++;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clrn = 1'b1;
        clr_ovf = 1'b0;
        fif.ps2_overflow = 1'b0;
        model_clear(1'b1);
        #1 clrn = 1'b0;
        #1;
        check("reset_rdn", fif.ps2_rdn, 1'b1);
        check("reset_valid", key_valid, 1'b0);
        check("reset_state", key_state, 8'h00);
        check("reset_last", last_make, 8'h00);
        check("reset_ovf", ovf_err, 1'b0);
        tick(3);
        clrn = 1'b1;
        tick(2);

        // Single make of W.
        p0 = rdn_pulses;
        send(8'h1D);
        drain();
        check("w_make_state", key_state, 8'h08);
        check("w_make_last", last_make, 8'h1D);
        check("w_make_pulses", 32'(rdn_pulses - p0), 32'd1);

        // Release of W.
        send(8'hF0); send(8'h1D);
        drain();
        check("w_break_state", key_state, 8'h00);
        check("w_break_last", last_make, 8'h1D);
        check("w_break_flag", key_break, 1'b1);

        // Extended Up make and break.
        p0 = rdn_pulses;
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        drain();
        check("up_pulses", 32'(rdn_pulses - p0), 32'd5);
        check("up_state", key_state, 8'h00);
        check("up_ext", key_ext, 1'b1);

        // Latency from ready to event strobe.
        send(8'h1C);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (key_valid !== 1'b1 && n < 10);
        check("latency", 32'(n), 32'd2);
        drain();
        send(8'h1D);
        drain();
        check("wa_state", key_state, 8'h0C);

        // Overflow with coincident clear: set wins, a later clear releases the flag.
        fif.ps2_overflow = 1'b1;
        clr_ovf = 1'b1;
        tick(1);
        model_clear(1'b0);
        check("ovf_set_wins", ovf_err, 1'b1);
        check("ovf_state", key_state, 8'h00);
        clr_ovf = 1'b0;
        tick(1);
        check("ovf_sticky", ovf_err, 1'b1);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        check("ovf_cleared", ovf_err, 1'b0);
        fif.ps2_overflow = 1'b0;
        tick(2);

        // Overflow discards a pending E0 prefix.
        send(8'hE0);
        drain();
        ovf_pulse();
        send(8'h75);
        drain();
        check("ovf_drops_ext", key_ext, 1'b0);

        // Long silence after a break prefix.
        send(8'hF0);
        drain();
        tick(150);
`ifdef PS2_KEY_TIMEOUT_EN
        model_clear(1'b0);
        m_held = key_state;
`endif
        send(8'h1C);
        drain();
`ifdef PS2_KEY_TIMEOUT_EN
        check("timeout_break", key_break, 1'b0);
        check("timeout_state", key_state, 8'h04);
`else
        check("persist_break", key_break, 1'b1);
        check("persist_state", key_state, 8'h00);
`endif

        // Reset while the pop strobe is low.
        model_clear(1'b1);
        send(8'h1D);
        tick(1);
        check("pop_rdn_low", fif.ps2_rdn, 1'b0);
        clrn = 1'b0;
        #1;
        check("rst_pop_rdn", fif.ps2_rdn, 1'b1);
        check("rst_pop_code", key_code, 8'h00);
        check("rst_pop_last", last_make, 8'h00);
        check("rst_pop_valid", key_valid, 1'b0);
        check("rst_pop_state", key_state, 8'h00);
        tick(2);
        clrn = 1'b1;
        drain();
        check("after_rst_state", key_state, 8'h08);
        check("after_rst_last", last_make, 8'h1D);

        // Random bursts, with occasional overflow while drained.
        for (int b = 0; b < 30; b++) begin
            int len;
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                send(rand_byte());
                if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 6));
            end
            drain();
            if ($urandom_range(0, 7) == 0) ovf_pulse();
            tick($urandom_range(0, 30));
        end

        drain();
        check("scoreboard_empty", 32'(exp_wr - exp_rd), 32'd0);
        check("rdn_total", 32'(rdn_pulses), 32'(tx_wr));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ps2_key_ctrl.md
PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 2: idle clk cycles after each pop before ps2_ready is sampled again (range 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 500000: prefix-expiry interval in clk cycles (20-bit; used only with REQ-024).
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge; clrn  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: ps2_data  in  8  FIFO head byte; ps2_ready  in  1  FIFO non-empty; ps2_overflow  in  1  FIFO overflow flag.
REQ-005 SHALL have port ps2_rdn  out  1  active-low pop strobe to the keyboard FIFO.
REQ-006 SHALL have ports: key_valid  out  1  one-cycle event strobe; key_code  out  8  event code; key_break  out  1  release event; key_ext  out  1  E0-prefixed event.
REQ-007 SHALL have ports: key_state  out  8  held keys {Right,Down,Left,Up,W,A,S,D} (bit7..bit0); last_make  out  8  most recent make code, for Seg7 display.
REQ-008 SHALL have ports: ovf_err  out  1  sticky overflow flag; clr_ovf  in  1  synchronous clear of ovf_err.

Function
REQ-009 SHALL sequence FIFO reads with a 3-state FSM: IDLE, POP, GAP.
REQ-010 In IDLE with ps2_ready=1, SHALL capture ps2_data into byte_r, drive ps2_rdn=0 on the next cycle, and go to POP.
REQ-011 POP SHALL last exactly one cycle with ps2_rdn=0, then go to GAP with ps2_rdn=1.
REQ-012 GAP SHALL last GAP_CYCLES cycles with ps2_rdn=1, then return to IDLE.
REQ-013 ps2_rdn SHALL be low only in POP; at most one pop per captured byte.
REQ-014 Parsing SHALL occur in POP on byte_r: 8'hE0 sets ext_pend; 8'hF0 sets brk_pend; no event for either.
REQ-015 Any other byte SHALL, in the POP cycle, yield key_valid=1 for exactly one cycle with key_code=byte_r, key_break=brk_pend, key_ext=ext_pend, then clear both pends.
REQ-016 key_code/key_break/key_ext SHALL hold their values until the next event.
REQ-017 Make events (key_break=0) SHALL load last_make=key_code in the same cycle as key_valid.
REQ-018 key_state SHALL set (make) or clear (break) on the event cycle; non-extended map: 1D->bit3 W, 1C->bit2 A, 1B->bit1 S, 23->bit0 D; extended map: 75->bit4 Up, 6B->bit5 Left, 72->bit6 Down, 74->bit7 Right; all other codes leave key_state unchanged.
REQ-019 Latency from ps2_ready rising in IDLE to key_valid SHALL be 2 cycles.
REQ-020 A rising edge of ps2_overflow SHALL set ovf_err and clear key_state, ext_pend and brk_pend in the same cycle; the FSM SHALL continue draining.
REQ-021 clr_ovf SHALL clear ovf_err; if an overflow rising edge coincides, set SHALL win.
REQ-022 ps2_ready dropping while in POP or GAP SHALL NOT abort the sequence; the FSM SHALL return to IDLE and wait.

Reset
REQ-023 On clrn=0, asynchronously: FSM=IDLE, ps2_rdn=1, key_valid=0, key_code=0, key_break=0, key_ext=0, key_state=0, last_make=0, ovf_err=0, pends=0, counters=0; reset mid-POP SHALL release ps2_rdn immediately.

Configuration
REQ-024 With macro PS2_KEY_TIMEOUT_EN defined, a counter SHALL run while ext_pend or brk_pend is set, restart on each captured byte, and clear both pends after TIMEOUT_CYCLES cycles with no further byte.
REQ-025 Without PS2_KEY_TIMEOUT_EN, there SHALL be no timeout counter; pends SHALL persist until the next non-prefix byte or an overflow.

Verification
REQ-026 FIFO bytes 1D -> one key_valid, key_code=1D, break=0, ext=0, key_state=8'h08, last_make=1D, exactly one 1-cycle ps2_rdn pulse.
REQ-027 Bytes 1D, F0, 1D -> two key_valid pulses, the second with break=1; key_state returns to 8'h00; last_make stays 1D.
REQ-028 Bytes E0, 75, E0, F0, 75 -> key_state=8'h10 after the make and 8'h00 after the break; both events have ext=1; exactly 5 rdn pulses.
REQ-029 With key_state=8'h0C, ps2_overflow rises -> ovf_err=1, key_state=8'h00; clr_ovf on the same cycle -> ovf_err stays 1; clr_ovf on a later cycle -> ovf_err=0.
REQ-030 clrn low while in POP -> ps2_rdn=1 and all outputs 0 without waiting for a clk edge; after release, a pending ready byte is processed normally.
REQ-031 With PS2_KEY_TIMEOUT_EN and TIMEOUT_CYCLES=100: byte F0, then 1C after 150 idle cycles -> key_break=0, key_state=8'h04; the same stimulus without the macro -> key_break=1, key_state unchanged.
